rf_2p_gen: RTL
==============

Name: rf_2p_gen

Overview:
Parametrised 2-port (1R/1W) register file with behavioural storage, generic depth/width and per-lane write mask. Successor to the fixed-size macro-based 2-port RF wrapper used by PE weight/activation buffers.
Adds an auto-clear sequencer (storage zeroed after reset or on request), a read-valid strobe and same-cycle write-to-read bypass. Sits between the buffer controllers and the PE datapath.

Parameters:
WORDS, 12, number of words; any value ≥2, not necessarily a power of 2
DWd, 32, data width in bits
LANES, 4, write-mask lanes; DWd must be divisible by LANES; lane width LWd = DWd/LANES
AWd, $clog2(WORDS), address width
BYPASS, 1, 1 = a read of the address written in the same cycle returns the merged new data; 0 = returns the old data

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_read  in  1  read request, valid only while o_ready=1
i_raddr  in  AWd  read address
i_write  in  1  write request, valid only while o_ready=1
i_waddr  in  AWd  write address
i_wdata  in  DWd  write data
i_wmask  in  LANES  per-lane write enable; lane k covers bits [k*LWd +: LWd]
i_clr  in  1  request a full storage clear
o_rdata  out  DWd  read data; holds its value between reads
o_rvalid  out  1  one-cycle strobe marking new o_rdata
o_ready  out  1  1 = READY state, requests accepted

Behaviour:
- Reset values: o_rdata=0, o_rvalid=0, o_ready=0; FSM=CLEAR; clr_addr=0. Storage itself has no reset and is zeroed by the sweep.
- FSM states: CLEAR and READY.
- CLEAR: each cycle writes 0 to mem[clr_addr] and increments clr_addr. When clr_addr==WORDS-1, the FSM goes to READY on the next cycle. The sweep takes exactly WORDS cycles.
- While in CLEAR: i_read, i_write and i_clr are ignored; o_rvalid=0.
- READY, o_ready=1: if i_clr=1, the FSM goes to CLEAR next cycle with clr_addr=0. Any read/write in that same cycle is still performed normally.
- Write: if i_write and i_waddr<WORDS, each lane with i_wmask[k]=1 is updated at the clock edge. Lanes with mask 0 keep their old value. i_wmask=0 means no change.
- Read: i_read in cycle t gives o_rdata and o_rvalid=1 in cycle t+1 (latency 1). Back-to-back reads give one result per cycle.
- Bypass, BYPASS=1: if i_read and i_write are both high and i_raddr==i_waddr, o_rdata takes i_wdata on masked lanes and the old word on the other lanes.
- Bypass, BYPASS=0: in the same case, o_rdata returns the pre-write word.
- Out of range, address ≥WORDS: the write is dropped. The read returns 0 with o_rvalid=1.
- i_rst in any cycle, including mid-sweep or with a read in flight: restarts CLEAR from address 0 and drops the in-flight o_rvalid.

Optional Feature:
RF2P_OUTREG_EN
- Defined: adds an output register stage. Read latency becomes 2, o_rvalid is delayed to match, and both stages reset to 0. Bypass merge is computed in stage 1. i_rst flushes both stages.
- Undefined: latency 1 as above.

Decomposition:
- Package rf2p_pkg:
  - enum rf2p_state_e {S_CLEAR, S_READY}
  - localparam function for lane width
  - helper function merging a word by lane mask, shared by the write path and the bypass path
- Sub-module rf2p_array: behavioural WORDS×DWd storage with masked write and asynchronous read index. The top level holds the FSM, clear counter, bypass and output registers.

Test Plan:
Bench configuration: WORDS=12, DWd=32, LANES=4.
1. Release i_rst → o_ready=0 for 12 cycles, then 1. Read addr 5 → o_rdata=0x00000000, o_rvalid=1 one cycle after i_read.
2. Write addr 3, data 0xDEADBEEF, mask 4'hF. Next cycle read 3 → o_rdata=0xDEADBEEF with o_rvalid pulse. Then 3 idle cycles → o_rdata still 0xDEADBEEF, o_rvalid=0.
3. mem[7]=0x11223344. Same cycle: write addr 7, data 0xAABBCCDD, mask 4'b0101, plus read 7.
   - BYPASS=1 → 0x11BB33DD.
   - BYPASS=0 → 0x11223344.
   - A later read of 7 → 0x11BB33DD in both cases.
4. Write addr 13, data 0x5A5A5A5A, then read 13 → o_rdata=0, o_rvalid=1; mem[0..11] unchanged.
5. After test 2, pulse i_clr while reading addr 3.
   - That read returns 0xDEADBEEF.
   - o_ready=0 for 12 cycles; read/write attempts during this window are ignored.
   - Read 3 after o_ready returns → 0.
6. Assert i_rst at sweep cycle 6 and, separately, in the cycle after an i_read → o_rvalid=0 and o_rdata=0 next cycle, o_ready=0 for 12 full cycles. With RF2P_OUTREG_EN, repeat test 2 → latency 2.

Source files
------------

// File: rtl/rf_2p_gen_pkg.sv
// Shared types and lane helpers for the generic 2-port register file.
// Merge helper works on MAX_DW/MAX_LANES containers; callers zero-extend in and cast back.
package rf2p_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } rf2p_state_e;

    localparam int MAX_DW    = 1024;
    localparam int MAX_LANES = 64;

    function automatic int lane_width(input int dw, input int lanes);
        return dw / lanes;
    endfunction

    // Bits whose lane mask is set take new_w, the rest keep old_w.
    function automatic logic [MAX_DW-1:0] merge_lanes(
        input logic [MAX_DW-1:0]    old_w,
        input logic [MAX_DW-1:0]    new_w,
        input logic [MAX_LANES-1:0] mask,
        input int                   lw
    );
        logic [MAX_DW-1:0] r;
        int                l;
        r = old_w;
        for (int b = 0; b < MAX_DW; b++) begin
            l = b / lw;
            if (l < MAX_LANES) begin
                if (mask[l]) r[b] = new_w[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_2p_gen_if.sv
// Request/response bundle between a buffer controller (master) and rf_2p_gen (slave).
interface rf_2p_gen_if #(
    parameter int AWd   = 4,
    parameter int DWd   = 32,
    parameter int LANES = 4
);
    logic             i_read;
    logic [AWd-1:0]   i_raddr;
    logic             i_write;
    logic [AWd-1:0]   i_waddr;
    logic [DWd-1:0]   i_wdata;
    logic [LANES-1:0] i_wmask;
    logic             i_clr;
    logic [DWd-1:0]   o_rdata;
    logic             o_rvalid;
    logic             o_ready;

    modport master (
        output i_read, i_raddr, i_write, i_waddr, i_wdata, i_wmask, i_clr,
        input  o_rdata, o_rvalid, o_ready
    );

    modport slave (
        input  i_read, i_raddr, i_write, i_waddr, i_wdata, i_wmask, i_clr,
        output o_rdata, o_rvalid, o_ready
    );
endinterface

// File: rtl/rf_2p_gen_array.sv
// Behavioural WORDS x DWd storage: lane-masked synchronous write, asynchronous read.
// Out-of-range write addresses are dropped and out-of-range reads return zero.
module rf2p_array
    import rf2p_pkg::*;
#(
    parameter int WORDS = 12,
    parameter int DWd   = 32,
    parameter int LANES = 4,
    parameter int AWd   = $clog2(WORDS)
) (
    input  logic             i_clk,
    input  logic             we,
    input  logic [AWd-1:0]   waddr,
    input  logic [DWd-1:0]   wdata,
    input  logic [LANES-1:0] wmask,
    input  logic [AWd-1:0]   raddr,
    output logic [DWd-1:0]   rdata
);
    localparam int             LWd     = lane_width(DWd, LANES);
    localparam logic [AWd:0]   WORDS_X = (AWd+1)'(WORDS);

    logic [DWd-1:0] mem [WORDS];

    always_ff @(posedge i_clk) begin
        if (we && ({1'b0, waddr} < WORDS_X))
            mem[waddr] <= DWd'(merge_lanes(MAX_DW'(mem[waddr]), MAX_DW'(wdata),
                                           MAX_LANES'(wmask), LWd));
    end

    assign rdata = ({1'b0, raddr} < WORDS_X) ? mem[raddr] : '0;

endmodule

// File: rtl/rf_2p_gen.sv
// Generic 1R/1W register file with auto-clear sweep, read-valid strobe and write bypass.
// Define RF2P_OUTREG_EN to add a second output register stage (read latency 2).
module rf_2p_gen
    import rf2p_pkg::*;
#(
    parameter int WORDS  = 12,
    parameter int DWd    = 32,
    parameter int LANES  = 4,
    parameter int AWd    = $clog2(WORDS),
    parameter int BYPASS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    rf_2p_gen_if.slave  bus
);
    localparam int             LWd     = lane_width(DWd, LANES);
    localparam logic [AWd:0]   WORDS_X = (AWd+1)'(WORDS);
    localparam logic [AWd-1:0] LAST_A  = AWd'(WORDS-1);

    rf2p_state_e      state_q, state_d;
    logic [AWd-1:0]   clr_addr_q, clr_addr_d;

    logic             arr_we;
    logic [AWd-1:0]   arr_waddr;
    logic [DWd-1:0]   arr_wdata;
    logic [LANES-1:0] arr_wmask;
    logic [DWd-1:0]   arr_rdata;

    logic             rd_fire;
    logic             raddr_ok, waddr_ok, wr_hit;
    logic [DWd-1:0]   rd_word;

    logic [DWd-1:0]   rdata1_q;
    logic             rvalid1_q;

    assign raddr_ok = {1'b0, bus.i_raddr} < WORDS_X;
    assign waddr_ok = {1'b0, bus.i_waddr} < WORDS_X;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // The sweep owns the write port while clearing; requests are ignored.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        arr_we     = 1'b0;
        arr_waddr  = bus.i_waddr;
        arr_wdata  = bus.i_wdata;
        arr_wmask  = bus.i_wmask;
        rd_fire    = 1'b0;
        case (state_q)
            S_CLEAR: begin
                arr_we    = 1'b1;
                arr_waddr = clr_addr_q;
                arr_wdata = '0;
                arr_wmask = '1;
                if (clr_addr_q == LAST_A) begin
                    state_d    = S_READY;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            S_READY: begin
                arr_we  = bus.i_write && waddr_ok;
                rd_fire = bus.i_read;
                if (bus.i_clr) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    rf2p_array #(
        .WORDS (WORDS),
        .DWd   (DWd),
        .LANES (LANES),
        .AWd   (AWd)
    ) u_array (
        .i_clk (i_clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wmask (arr_wmask),
        .raddr (bus.i_raddr),
        .rdata (arr_rdata)
    );

    assign wr_hit = (BYPASS != 0) && bus.i_write && waddr_ok && (bus.i_waddr == bus.i_raddr);

    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            if (wr_hit)
                rd_word = DWd'(merge_lanes(MAX_DW'(arr_rdata), MAX_DW'(bus.i_wdata),
                                           MAX_LANES'(bus.i_wmask), LWd));
            else
                rd_word = arr_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata1_q  <= '0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid1_q <= rd_fire;
            if (rd_fire) rdata1_q <= rd_word;
        end
    end

`ifdef RF2P_OUTREG_EN
    logic [DWd-1:0] rdata2_q;
    logic           rvalid2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata2_q  <= '0;
            rvalid2_q <= 1'b0;
        end else begin
            rvalid2_q <= rvalid1_q;
            if (rvalid1_q) rdata2_q <= rdata1_q;
        end
    end

    assign bus.o_rdata  = rdata2_q;
    assign bus.o_rvalid = rvalid2_q;
`else
    assign bus.o_rdata  = rdata1_q;
    assign bus.o_rvalid = rvalid1_q;
`endif

    assign bus.o_ready = (state_q == S_READY);

endmodule
